integ_dump: RTL and testbench

Streaming integrate-and-dump decimator for the front-end datapath. It sums `DEC` consecutive accepted signed samples and emits one full-precision sum per frame, then clears. It sits directly upstream of the rounding stage. With defaults, its 7-bit output matches that stage's 7-bit input.

---
 rtl/integ_dump.sv | 80 ++++++++
 tb/tb_integ_dump.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/integ_dump.sv
// Integrate-and-dump decimator: sums DEC accepted signed samples at full
// precision and emits one registered sum per frame.
module integ_dump #(
  parameter  int NBW_IN  = 5,
  parameter  int DEC     = 4,
  localparam int NBW_ACC = NBW_IN + $clog2(DEC)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_async_n,
  input  logic                      i_clear,
  input  logic signed [NBW_IN-1:0]  i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic signed [NBW_ACC-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready
);

  localparam int CNT_W = $clog2(DEC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEC - 1);

  typedef enum logic {PH_ACCUM, PH_LAST} phase_t;

  logic signed [NBW_ACC-1:0] acc, acc_nxt, sum, odata_nxt;
  logic        [CNT_W-1:0]   cnt, cnt_nxt;
  logic                      ovalid_nxt, accept, consume;
  phase_t                    phase;

  function automatic logic signed [NBW_ACC-1:0] sxt(input logic signed [NBW_IN-1:0] d);
    return NBW_ACC'(d);
  endfunction

  assign phase   = (cnt == LAST_CNT) ? PH_LAST : PH_ACCUM;
  // Stall only when a dump would overwrite a result downstream has not taken.
  assign o_ready = !i_clear && !(phase == PH_LAST && o_valid && !i_ready);
  assign accept  = i_valid && o_ready;
  assign consume = o_valid && i_ready;
  assign sum     = acc + sxt(i_data);

  always_comb begin
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    odata_nxt  = o_data;
    ovalid_nxt = o_valid && !consume;
    if (i_clear) begin
      acc_nxt    = '0;
      cnt_nxt    = '0;
      ovalid_nxt = 1'b0;
    end else if (accept) begin
      unique case (phase)
        PH_ACCUM: begin
          acc_nxt = sum;
          cnt_nxt = cnt + CNT_W'(1);
        end
        PH_LAST: begin
          odata_nxt  = sum;
          ovalid_nxt = 1'b1;
          acc_nxt    = '0;
          cnt_nxt    = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_async_n) begin
    if (!i_rst_async_n) begin
      acc     <= '0;
      cnt     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      o_data  <= odata_nxt;
      o_valid <= ovalid_nxt;
    end
  end

endmodule

// File: tb/tb_integ_dump.sv
// Directed bench for integ_dump with default parameters (NBW_IN=5, DEC=4).
module tb_integ_dump;

  logic              i_clk = 1'b0;
  logic              i_rst_async_n = 1'b0;
  logic              i_clear = 1'b0;
  logic signed [4:0] i_data = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic signed [6:0] o_data;
  logic              o_valid;
  logic              i_ready = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  integ_dump dut (
    .i_clk         (i_clk),
    .i_rst_async_n (i_rst_async_n),
    .i_clear       (i_clear),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [4:0] d);
    i_valid = v;
    i_data  = d;
  endtask

  task automatic test_reset();
    i_rst_async_n = 1'b0;
    tick();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else pass_cnt++;
    total_cnt++;
    if (o_data !== 7'sd0) $display("FAIL reset_data got %0d want 0", o_data); else pass_cnt++;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else pass_cnt++;
    i_rst_async_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic signed [4:0] v [4] = '{5'sd3, 5'sd5, -5'sd2, 5'sd7};
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i]);
      tick();
      total_cnt++;
      if (o_valid !== (i == 3)) $display("FAIL basic_valid[%0d] got %b want %b", i, o_valid, (i == 3));
      else pass_cnt++;
    end
    total_cnt++;
    if (o_data !== 7'sd13) $display("FAIL basic_data got %0d want 13", o_data); else pass_cnt++;
    drive(1'b0, '0);
    tick();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL basic_pulse got %b want 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_extremes();
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i < 4) ? -5'sd16 : 5'sd15);
      tick();
      total_cnt++;
      if (o_valid !== (i == 3 || i == 7))
        $display("FAIL ext_valid[%0d] got %b want %b", i, o_valid, (i == 3 || i == 7));
      else pass_cnt++;
      if (i == 3) begin
        total_cnt++;
        if (o_data !== -7'sd64) $display("FAIL ext_min got %0d want -64", o_data); else pass_cnt++;
      end
      if (i == 7) begin
        total_cnt++;
        if (o_data !== 7'sd60) $display("FAIL ext_max got %0d want 60", o_data); else pass_cnt++;
      end
    end
    drive(1'b0, '0);
    tick();
  endtask

  task automatic test_backpressure();
    logic signed [4:0] v [4] = '{5'sd3, 5'sd5, -5'sd2, 5'sd7};
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i]);
      tick();
    end
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 7'sd13)
      $display("FAIL bp_first got v=%b d=%0d want v=1 d=13", o_valid, o_data);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'sd1);
      #1;
      total_cnt++;
      if (o_ready !== 1'b1) $display("FAIL bp_accum_ready[%0d] got %b want 1", i, o_ready); else pass_cnt++;
      tick();
    end
    drive(1'b1, 5'sd1);
    #1;
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", o_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 7'sd13)
      $display("FAIL bp_hold got v=%b d=%0d want v=1 d=13", o_valid, o_data);
    else pass_cnt++;
    i_ready = 1'b1;
    #1;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", o_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 7'sd4)
      $display("FAIL bp_second got v=%b d=%0d want v=1 d=4", o_valid, o_data);
    else pass_cnt++;
    drive(1'b0, '0);
    tick();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic vv [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    i_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vv[i], vv[i] ? 5'sd2 : 5'sd9);
      tick();
      total_cnt++;
      if (o_valid !== (i == 6)) $display("FAIL gap_valid[%0d] got %b want %b", i, o_valid, (i == 6));
      else pass_cnt++;
    end
    total_cnt++;
    if (o_data !== 7'sd8) $display("FAIL gap_data got %0d want 8", o_data); else pass_cnt++;
    drive(1'b0, '0);
    tick();
  endtask

  task automatic test_clear();
    i_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'sd9);
      tick();
    end
    i_clear = 1'b1;
    drive(1'b1, 5'sd9);
    #1;
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL clr_ready got %b want 0", o_ready); else pass_cnt++;
    tick();
    i_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'sd1);
      tick();
      total_cnt++;
      if (o_valid !== (i == 3)) $display("FAIL clr_valid[%0d] got %b want %b", i, o_valid, (i == 3));
      else pass_cnt++;
    end
    total_cnt++;
    if (o_data !== 7'sd4) $display("FAIL clr_data got %0d want 4", o_data); else pass_cnt++;
    drive(1'b0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'sd1);
      tick();
    end
    drive(1'b0, '0);
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 7'sd4)
      $display("FAIL rst_pending got v=%b d=%0d want v=1 d=4", o_valid, o_data);
    else pass_cnt++;
    #2;
    i_rst_async_n = 1'b0;
    #1;
    total_cnt++;
    if (o_valid !== 1'b0 || o_data !== 7'sd0)
      $display("FAIL rst_async got v=%b d=%0d want v=0 d=0", o_valid, o_data);
    else pass_cnt++;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", o_ready); else pass_cnt++;
    tick();
    i_rst_async_n = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, -5'sd1);
      tick();
      total_cnt++;
      if (o_valid !== (i == 3)) $display("FAIL rst_valid[%0d] got %b want %b", i, o_valid, (i == 3));
      else pass_cnt++;
    end
    total_cnt++;
    if (o_data !== -7'sd4) $display("FAIL rst_data got %0d want -4", o_data); else pass_cnt++;
    drive(1'b0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
